wb_cfg_master: RTL and testbench
================================

# wb_cfg_master

Wishbone classic single-cycle master that turns a valid/ready command stream into Wishbone read and write cycles aimed at the accelerator's configuration slave. It sits between a host-side loader (UART bridge, SPI boot FSM or testbench driver) and the `cfg` Wishbone port, and it lets conv1/conv2/fc weights be loaded and read back without the Caravel management core. Read data and bus errors come back on a response stream. A watchdog ends any cycle the slave never acknowledges.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles `wbm_stb_o` stays high without `wbm_ack_i`; range 1..65535.
- `RSP_ON_WRITE`, 0: 1 = writes also emit a response beat; 0 = only reads and timed-out writes emit one.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset.
- One clock; reset is synchronous and active-high.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: block can accept a command.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_adr_i` in 32: byte address, e.g. 32'h3000_0000 and up.
- `cmd_dat_i` in 32: write data.
- `cmd_sel_i` in 4: byte selects.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: consumer accepts the response.
- `rsp_dat_o` out 32: read data; 0 for writes and timeouts.
- `rsp_err_o` out 1: 1 = cycle ended by timeout.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: Wishbone controls.
- `wbm_adr_o` out 32, `wbm_dat_o` out 32, `wbm_sel_o` out 4: Wishbone address, write data, byte selects.
- `wbm_ack_i` in 1, `wbm_dat_i` in 32: Wishbone acknowledge and read data.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- States:
  - IDLE: `cmd_ready_o`=1.
  - BUS: `cyc`/`stb`=1.
  - RESP: `rsp_valid_o`=1.
- IDLE→BUS on `cmd_valid_i & cmd_ready_o`. Command fields are registered into the `wbm_*` outputs. Watchdog counter is cleared to 0.
- BUS:
  - Each cycle without ack, counter increments.
  - On `wbm_ack_i`=1: capture `wbm_dat_i` when the command is a read, and set `rsp_err_o`=0.
  - After ack: go to RESP if (read or `RSP_ON_WRITE`), else to IDLE.
- BUS timeout: if the counter reaches `TIMEOUT_CYCLES` with no ack, set `rsp_err_o`=1 and `rsp_dat_o`=0, then go to RESP for reads and writes alike.
- If ack and timeout occur in the same cycle, ack wins: `rsp_err_o`=0.
- RESP→IDLE on `rsp_ready_i`. Response fields hold stable while `rsp_ready_i`=0.
- Only one transaction is ever outstanding. `cmd_ready_o` is 0 in BUS and RESP.
- `wbm_ack_i` outside BUS is ignored.
- Counter is 16 bits and saturates; it never wraps.
- Reset, including mid-BUS or mid-RESP:
  - Next edge returns to IDLE and the in-flight command is dropped with no response.
  - All outputs go to 0 except `cmd_ready_o`, which goes to 1.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Command accepted at edge N: `cyc`/`stb`/`adr`/`we`/`dat`/`sel` are valid from N+1.
- Ack high during cycle M (sampled at edge M+1):
  - `cyc`/`stb` low from M+1.
  - `rsp_valid_o`=1 from M+1.
  - A zero-wait slave holds `stb` exactly 1 cycle.
- `wbm_adr_o`, `wbm_dat_o`, `wbm_sel_o`, `wbm_we_o` hold their values until the next command is accepted.
- Timeout: `stb` is high for exactly `TIMEOUT_CYCLES` cycles, then low, with `rsp_valid_o` rising the same edge.
- Throughput, with zero-wait ack and `rsp_ready_i`=1:
  - Write with no response: 2 cycles per command (accept, bus).
  - Read: 3 cycles per command (accept, bus, resp).

## Test plan
- Write 32'h3000_0004 / 32'h1234_5678 / sel 4'hF, slave acks 2 cycles after `stb` rises, `RSP_ON_WRITE`=0 → `stb` high 3 cycles with `adr`/`dat` stable, `we`=1; no response beat; `cmd_ready_o` returns 1 the cycle after `stb` falls.
- Read 32'h3000_0010, zero-wait slave returns 32'hA5A5_5A5A → `stb` high 1 cycle, `we`=0; `rsp_valid_o`=1 with `rsp_dat_o`=32'hA5A5_5A5A and `rsp_err_o`=0.
- `TIMEOUT_CYCLES`=4, write with no ack → `stb` high exactly 4 cycles; response `rsp_err_o`=1, `rsp_dat_o`=0; an ack arriving 2 cycles later is ignored.
- Ack arriving on the cycle the counter hits `TIMEOUT_CYCLES` → `rsp_err_o`=0 and read data captured.
- Read response held with `rsp_ready_i`=0 for 5 cycles while `cmd_valid_i`=1 → `rsp_valid_o` and `rsp_dat_o` stable, `cmd_ready_o`=0; the next command is accepted on the edge after `rsp_ready_i` rises.
- `rst_i` asserted 1 cycle mid-BUS → next edge `cyc`/`stb`=0, `busy_o`=0, `cmd_ready_o`=1, no response; the following command completes normally.

Source files
------------

// File: rtl/wb_cfg_master_if.sv
// Command/response streams and Wishbone classic master bus of wb_cfg_master.
// The master modport is the block's view; slave is the loader/slave side.
interface wb_cfg_master_if;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_we_i;
   logic [31:0] cmd_adr_i;
   logic [31:0] cmd_dat_i;
   logic [3:0]  cmd_sel_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_ack_i;
   logic [31:0] wbm_dat_i;
   logic        busy_o;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
      input  rsp_ready_i, wbm_ack_i, wbm_dat_i,
      output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
      output busy_o
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
      output rsp_ready_i, wbm_ack_i, wbm_dat_i,
      input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
      input  busy_o
   );
endinterface

// File: rtl/wb_cfg_master.sv
// Wishbone classic single-outstanding master: one command in, one bus cycle,
// optional response beat; a saturating watchdog ends unacknowledged cycles.
module wb_cfg_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          RSP_ON_WRITE   = 1'b0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   wb_cfg_master_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);

   state_t      state_r;
   logic [15:0] cnt_r;
   logic        cmd_ready_r;
   logic        rsp_valid_r;
   logic [31:0] rsp_dat_r;
   logic        rsp_err_r;
   logic        cyc_r;
   logic        stb_r;
   logic        we_r;
   logic [31:0] adr_r;
   logic [31:0] dat_r;
   logic [3:0]  sel_r;
   logic        busy_r;
   logic        timeout_s;

   // Timeout fires on the edge that would bring the counter to the limit,
   // so stb stays high for exactly TIMEOUT_CYCLES cycles.
   always_comb begin
      timeout_s = 1'b0;
      if (({1'b0, cnt_r} + 17'd1) >= TMO_LIMIT) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 16'd0;
         cmd_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_dat_r   <= 32'd0;
         rsp_err_r   <= 1'b0;
         cyc_r       <= 1'b0;
         stb_r       <= 1'b0;
         we_r        <= 1'b0;
         adr_r       <= 32'd0;
         dat_r       <= 32'd0;
         sel_r       <= 4'd0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.cmd_valid_i) begin
                  state_r     <= ST_BUS;
                  cmd_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  cyc_r       <= 1'b1;
                  stb_r       <= 1'b1;
                  we_r        <= bus.cmd_we_i;
                  adr_r       <= bus.cmd_adr_i;
                  dat_r       <= bus.cmd_dat_i;
                  sel_r       <= bus.cmd_sel_i;
                  cnt_r       <= 16'd0;
               end
            end
            ST_BUS: begin
               if (bus.wbm_ack_i) begin
                  // Ack has priority over a simultaneous timeout.
                  cyc_r     <= 1'b0;
                  stb_r     <= 1'b0;
                  rsp_err_r <= 1'b0;
                  rsp_dat_r <= we_r ? 32'd0 : bus.wbm_dat_i;
                  if (!we_r || RSP_ON_WRITE) begin
                     state_r     <= ST_RESP;
                     rsp_valid_r <= 1'b1;
                  end else begin
                     state_r     <= ST_IDLE;
                     cmd_ready_r <= 1'b1;
                     busy_r      <= 1'b0;
                  end
               end else if (timeout_s) begin
                  cyc_r       <= 1'b0;
                  stb_r       <= 1'b0;
                  rsp_err_r   <= 1'b1;
                  rsp_dat_r   <= 32'd0;
                  rsp_valid_r <= 1'b1;
                  state_r     <= ST_RESP;
               end else if (cnt_r != 16'hFFFF) begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid_r <= 1'b0;
                  cmd_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cmd_ready_r <= 1'b1;
               rsp_valid_r <= 1'b0;
               cyc_r       <= 1'b0;
               stb_r       <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready_o = cmd_ready_r;
   assign bus.rsp_valid_o = rsp_valid_r;
   assign bus.rsp_dat_o   = rsp_dat_r;
   assign bus.rsp_err_o   = rsp_err_r;
   assign bus.wbm_cyc_o   = cyc_r;
   assign bus.wbm_stb_o   = stb_r;
   assign bus.wbm_we_o    = we_r;
   assign bus.wbm_adr_o   = adr_r;
   assign bus.wbm_dat_o   = dat_r;
   assign bus.wbm_sel_o   = sel_r;
   assign bus.busy_o      = busy_r;

endmodule

// File: tb/tb_wb_cfg_master.sv
// Directed bench for wb_cfg_master (TIMEOUT_CYCLES=4, RSP_ON_WRITE=0);
// the bench plays both the command source and the Wishbone slave.
module tb_wb_cfg_master;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   wb_cfg_master_if bus ();

   wb_cfg_master #(.TIMEOUT_CYCLES(4), .RSP_ON_WRITE(1'b0)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs settled, inputs safe to change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = we;
      bus.cmd_adr_i   = adr;
      bus.cmd_dat_i   = dat;
      bus.cmd_sel_i   = 4'hF;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_adr_i   = 32'd0;
      bus.cmd_dat_i   = 32'd0;
      bus.cmd_sel_i   = 4'd0;
      bus.rsp_ready_i = 1'b0;
      bus.wbm_ack_i   = 1'b0;
      bus.wbm_dat_i   = 32'd0;
      tick();
      tick();
      chk("rst_ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("rst_cyc",   32'(bus.wbm_cyc_o),   32'd0);
      chk("rst_stb",   32'(bus.wbm_stb_o),   32'd0);
      chk("rst_rspv",  32'(bus.rsp_valid_o), 32'd0);
      chk("rst_busy",  32'(bus.busy_o),      32'd0);
      chk("rst_adr",   bus.wbm_adr_o,        32'd0);
      rst = 1'b0;
      tick();

      // Write, slave acks on the third stb cycle, no response beat.
      send(1'b1, 32'h3000_0004, 32'h1234_5678);
      tick();
      bus.cmd_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("wr_stb",   32'(bus.wbm_stb_o),   32'd1);
         chk("wr_cyc",   32'(bus.wbm_cyc_o),   32'd1);
         chk("wr_adr",   bus.wbm_adr_o,        32'h3000_0004);
         chk("wr_dat",   bus.wbm_dat_o,        32'h1234_5678);
         chk("wr_we",    32'(bus.wbm_we_o),    32'd1);
         chk("wr_sel",   32'(bus.wbm_sel_o),   32'hF);
         chk("wr_ready", 32'(bus.cmd_ready_o), 32'd0);
         chk("wr_busy",  32'(bus.busy_o),      32'd1);
         if (i == 2) bus.wbm_ack_i = 1'b1;
         tick();
      end
      bus.wbm_ack_i = 1'b0;
      chk("wr_stb_low",  32'(bus.wbm_stb_o),   32'd0);
      chk("wr_norsp",    32'(bus.rsp_valid_o), 32'd0);
      chk("wr_ready1",   32'(bus.cmd_ready_o), 32'd1);
      chk("wr_adr_hold", bus.wbm_adr_o,        32'h3000_0004);

      // Zero-wait read.
      bus.rsp_ready_i = 1'b1;
      send(1'b0, 32'h3000_0010, 32'd0);
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("rd_stb", 32'(bus.wbm_stb_o), 32'd1);
      chk("rd_we",  32'(bus.wbm_we_o),  32'd0);
      chk("rd_adr", bus.wbm_adr_o,      32'h3000_0010);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'hA5A5_5A5A;
      tick();
      bus.wbm_ack_i = 1'b0;
      chk("rd_stb_low", 32'(bus.wbm_stb_o),   32'd0);
      chk("rd_rspv",    32'(bus.rsp_valid_o), 32'd1);
      chk("rd_dat",     bus.rsp_dat_o,        32'hA5A5_5A5A);
      chk("rd_err",     32'(bus.rsp_err_o),   32'd0);
      chk("rd_ready0",  32'(bus.cmd_ready_o), 32'd0);
      tick();
      chk("rd_done", 32'(bus.rsp_valid_o), 32'd0);
      chk("rd_idle", 32'(bus.cmd_ready_o), 32'd1);

      // Write that never gets acked: stb for exactly 4 cycles.
      bus.rsp_ready_i = 1'b0;
      send(1'b1, 32'h3000_0020, 32'hDEAD_BEEF);
      tick();
      bus.cmd_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("to_stb",  32'(bus.wbm_stb_o),   32'd1);
         chk("to_rspv", 32'(bus.rsp_valid_o), 32'd0);
         tick();
      end
      chk("to_stb_low", 32'(bus.wbm_stb_o),   32'd0);
      chk("to_cyc_low", 32'(bus.wbm_cyc_o),   32'd0);
      chk("to_rspv1",   32'(bus.rsp_valid_o), 32'd1);
      chk("to_err",     32'(bus.rsp_err_o),   32'd1);
      chk("to_dat",     bus.rsp_dat_o,        32'd0);
      tick();
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'h1111_2222;
      tick();
      bus.wbm_ack_i = 1'b0;
      chk("late_ack_err",  32'(bus.rsp_err_o),   32'd1);
      chk("late_ack_dat",  bus.rsp_dat_o,        32'd0);
      chk("late_ack_rspv", 32'(bus.rsp_valid_o), 32'd1);
      chk("late_ack_stb",  32'(bus.wbm_stb_o),   32'd0);
      bus.rsp_ready_i = 1'b1;
      tick();
      chk("to_idle", 32'(bus.cmd_ready_o), 32'd1);

      // Ack on the final watchdog cycle wins over the timeout.
      send(1'b0, 32'h3000_0030, 32'd0);
      tick();
      bus.cmd_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("race_stb", 32'(bus.wbm_stb_o), 32'd1);
         if (i == 3) begin
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = 32'hCAFE_F00D;
         end
         tick();
      end
      bus.wbm_ack_i = 1'b0;
      chk("race_rspv", 32'(bus.rsp_valid_o), 32'd1);
      chk("race_err",  32'(bus.rsp_err_o),   32'd0);
      chk("race_dat",  bus.rsp_dat_o,        32'hCAFE_F00D);
      tick();
      chk("race_idle", 32'(bus.cmd_ready_o), 32'd1);

      // Response back-pressure with the next command already waiting.
      bus.rsp_ready_i = 1'b0;
      send(1'b0, 32'h3000_0040, 32'd0);
      tick();
      send(1'b0, 32'h3000_0044, 32'd0);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'h1357_9BDF;
      tick();
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("hold_rspv",  32'(bus.rsp_valid_o), 32'd1);
         chk("hold_dat",   bus.rsp_dat_o,        32'h1357_9BDF);
         chk("hold_ready", 32'(bus.cmd_ready_o), 32'd0);
         chk("hold_stb",   32'(bus.wbm_stb_o),   32'd0);
         tick();
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      chk("hold_rel_rspv", 32'(bus.rsp_valid_o), 32'd0);
      chk("hold_rel_rdy",  32'(bus.cmd_ready_o), 32'd1);
      chk("hold_rel_stb",  32'(bus.wbm_stb_o),   32'd0);
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("next_stb", 32'(bus.wbm_stb_o), 32'd1);
      chk("next_adr", bus.wbm_adr_o,      32'h3000_0044);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'h0000_0001;
      tick();
      bus.wbm_ack_i = 1'b0;
      chk("next_dat", bus.rsp_dat_o, 32'h0000_0001);
      tick();

      // Reset in the middle of a bus cycle drops the command.
      send(1'b1, 32'h3000_0050, 32'h5555_AAAA);
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("mid_stb", 32'(bus.wbm_stb_o), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_cyc",   32'(bus.wbm_cyc_o),   32'd0);
      chk("mid_rst_stb",   32'(bus.wbm_stb_o),   32'd0);
      chk("mid_rst_busy",  32'(bus.busy_o),      32'd0);
      chk("mid_rst_ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("mid_rst_rspv",  32'(bus.rsp_valid_o), 32'd0);
      chk("mid_rst_adr",   bus.wbm_adr_o,        32'd0);
      tick();
      chk("mid_rst_norsp", 32'(bus.rsp_valid_o), 32'd0);
      send(1'b0, 32'h3000_0060, 32'd0);
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("post_stb", 32'(bus.wbm_stb_o), 32'd1);
      chk("post_adr", bus.wbm_adr_o,      32'h3000_0060);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'h2468_ACE0;
      tick();
      bus.wbm_ack_i = 1'b0;
      chk("post_rspv", 32'(bus.rsp_valid_o), 32'd1);
      chk("post_dat",  bus.rsp_dat_o,        32'h2468_ACE0);
      chk("post_err",  32'(bus.rsp_err_o),   32'd0);
      tick();
      chk("post_idle", 32'(bus.cmd_ready_o), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
